// File: rtl/amm_rd_checker.sv
// Read-side checker: holds one descriptor per issued read burst and compares
// the returned beats against the expected pattern. Reports sticky errors, a
// saturating mismatch count and the location of the first failing byte.
module amm_rd_checker #(
  parameter int AMM_DATA_W  = 128,
  parameter int AMM_BURST_W = 11,
  parameter int ADDR_W      = 6,
  parameter int DESC_DEPTH  = 4,
  parameter int ERR_CNT_W   = 16,
  localparam int BPW        = AMM_DATA_W / 8,
  localparam int BYTE_W     = $clog2(BPW)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   desc_valid_i,
  output logic                   desc_ready_o,
  input  logic [ADDR_W-1:0]      desc_addr_i,
  input  logic [AMM_BURST_W-1:0] desc_words_i,
  input  logic [BPW-1:0]         desc_start_mask_i,
  input  logic [BPW-1:0]         desc_end_mask_i,
  input  logic [7:0]             desc_ptrn_i,
  input  logic                   desc_ptrn_type_i,
  input  logic [AMM_DATA_W-1:0]  readdata_i,
  input  logic                   readdatavalid_i,
  input  logic                   clear_i,
  output logic                   busy_o,
  output logic                   burst_done_o,
  output logic                   err_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o,
  output logic                   orphan_o,
  output logic [ADDR_W-1:0]      first_err_addr_o,
  output logic [BYTE_W-1:0]      first_err_byte_o
);
  localparam int PW = $clog2(DESC_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]      addr;
    logic [AMM_BURST_W-1:0] words;
    logic [BPW-1:0]         smask;
    logic [BPW-1:0]         emask;
    logic [7:0]             ptrn;
    logic                   ptype;
  } desc_t;

  desc_t                  mem [DESC_DEPTH];
  desc_t                  head;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   empty, full, push, pop, beat, orphan_beat, last;
  logic [AMM_BURST_W-1:0] beat_idx;
  logic [7:0]             lfsr, lfsr_nxt;
  logic [BPW-1:0]         mask, lane_bad;
  logic                   mismatch;
  logic [BYTE_W-1:0]      first_lane;
  logic [ADDR_W-1:0]      word_addr;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  assign empty       = (count == '0);
  assign full        = (count == CW'(DESC_DEPTH));
  assign head        = mem[rd_ptr];
  assign beat        = readdatavalid_i && !empty;
  assign orphan_beat = readdatavalid_i && empty;
  assign last        = (beat_idx == head.words - AMM_BURST_W'(1));
  assign pop         = beat && last;
  // A full FIFO still accepts when the head retires in the same cycle.
  assign desc_ready_o = !full || pop;
  assign push        = desc_valid_i && desc_ready_o && (desc_words_i != '0);
  assign busy_o      = !empty;
  assign word_addr   = head.addr + ADDR_W'(beat_idx);

  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= '{addr: desc_addr_i, words: desc_words_i,
                       smask: desc_start_mask_i, emask: desc_end_mask_i,
                       ptrn: desc_ptrn_i, ptype: desc_ptrn_type_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    mask = '1;
    if (head.words == AMM_BURST_W'(1)) mask = head.smask & head.emask;
    else if (beat_idx == '0)          mask = head.smask;
    else if (last)                    mask = head.emask;
  end

  // Lane k sees the LFSR after k steps; masked lanes still advance it.
  always_comb begin
    logic [7:0] st;
    logic [7:0] exp_b;
    st = (beat_idx == '0) ? ((head.ptrn == 8'h00) ? 8'hFF : head.ptrn) : lfsr;
    lane_bad = '0;
    for (int k = 0; k < BPW; k++) begin
      exp_b       = head.ptype ? st : head.ptrn;
      lane_bad[k] = mask[k] && (readdata_i[8*k +: 8] != exp_b);
      st          = lfsr_step(st);
    end
    lfsr_nxt = st;
    mismatch = |lane_bad;
  end

  always_comb begin
    first_lane = '0;
    for (int k = BPW - 1; k >= 0; k--)
      if (lane_bad[k]) first_lane = BYTE_W'(k);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_idx <= '0;
      lfsr     <= '0;
    end else if (beat) begin
      beat_idx <= last ? '0 : beat_idx + AMM_BURST_W'(1);
      lfsr     <= lfsr_nxt;
    end
  end

  // Later assignments win: a mismatch or orphan in a clear cycle still lands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o            <= 1'b0;
      orphan_o         <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
      first_err_byte_o <= '0;
      burst_done_o     <= 1'b0;
    end else begin
      burst_done_o <= pop;
      if (clear_i) begin
        err_o            <= 1'b0;
        orphan_o         <= 1'b0;
        err_cnt_o        <= '0;
        first_err_addr_o <= '0;
        first_err_byte_o <= '0;
      end
      if (beat && mismatch) begin
        err_o <= 1'b1;
        if (clear_i)         err_cnt_o <= ERR_CNT_W'(1);
        else if (!(&err_cnt_o)) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
        if (!err_o || clear_i) begin
          first_err_addr_o <= word_addr;
          first_err_byte_o <= first_lane;
        end
      end
      if (orphan_beat) begin
        orphan_o <= 1'b1;
        err_o    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_amm_rd_checker.sv
// Directed bench for amm_rd_checker: table of single-burst vectors plus
// hand sequences for flow control, orphan/clear and reset mid-burst.
module tb_amm_rd_checker;
  logic         clk_i = 0, rst_i = 1;
  logic         desc_valid_i = 0, desc_ready_o;
  logic [5:0]   desc_addr_i = 0;
  logic [10:0]  desc_words_i = 0;
  logic [15:0]  desc_start_mask_i = 0, desc_end_mask_i = 0;
  logic [7:0]   desc_ptrn_i = 0;
  logic         desc_ptrn_type_i = 0;
  logic [127:0] readdata_i = 0;
  logic         readdatavalid_i = 0, clear_i = 0;
  logic         busy_o, burst_done_o, err_o, orphan_o;
  logic [15:0]  err_cnt_o;
  logic [5:0]   first_err_addr_o;
  logic [3:0]   first_err_byte_o;

  amm_rd_checker dut (
    .clk_i(clk_i), .rst_i(rst_i), .desc_valid_i(desc_valid_i),
    .desc_ready_o(desc_ready_o), .desc_addr_i(desc_addr_i),
    .desc_words_i(desc_words_i), .desc_start_mask_i(desc_start_mask_i),
    .desc_end_mask_i(desc_end_mask_i), .desc_ptrn_i(desc_ptrn_i),
    .desc_ptrn_type_i(desc_ptrn_type_i), .readdata_i(readdata_i),
    .readdatavalid_i(readdatavalid_i), .clear_i(clear_i), .busy_o(busy_o),
    .burst_done_o(burst_done_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
    .orphan_o(orphan_o), .first_err_addr_o(first_err_addr_o),
    .first_err_byte_o(first_err_byte_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0]        addr;
    logic [10:0]       words;
    logic [15:0]       sm, em;
    logic [7:0]        ptrn;
    logic              typ;
    logic [3:0][127:0] data;
    logic              exp_err;
    logic [15:0]       exp_cnt;
    logic [5:0]        exp_fa;
    logic [3:0]        exp_fb;
  } vec_t;

  vec_t vt [7];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  function automatic vec_t mk(input logic [5:0] a, input logic [10:0] w,
                              input logic [15:0] sm, input logic [15:0] em,
                              input logic [7:0] p, input logic ty, input logic e,
                              input logic [15:0] c, input logic [5:0] fa,
                              input logic [3:0] fb);
    vec_t v;
    v.addr = a; v.words = w; v.sm = sm; v.em = em; v.ptrn = p; v.typ = ty;
    for (int i = 0; i < 4; i++) v.data[i] = {16{p}};
    v.exp_err = e; v.exp_cnt = c; v.exp_fa = fa; v.exp_fb = fb;
    return v;
  endfunction

  task automatic push(input logic [5:0] a, input logic [10:0] w, input logic [15:0] sm,
                      input logic [15:0] em, input logic [7:0] p, input logic ty);
    desc_addr_i = a; desc_words_i = w; desc_start_mask_i = sm;
    desc_end_mask_i = em; desc_ptrn_i = p; desc_ptrn_type_i = ty;
    desc_valid_i = 1;
    for (int t = 0; t < 20 && !desc_ready_o; t++) tick;
    chk("push_ready", desc_ready_o, 1'b1);
    tick;
    desc_valid_i = 0;
  endtask

  task automatic beat(input logic [127:0] d);
    readdata_i = d;
    readdatavalid_i = 1;
    tick;
    readdatavalid_i = 0;
  endtask

  task automatic clear;
    clear_i = 1;
    tick;
    clear_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] st;
    // Vector table
    vt[0] = mk(6'd5, 11'd3, 16'hFFFF, 16'hFFFF, 8'hA5, 0, 0, 0, 0, 0);
    vt[1] = mk(6'd0, 11'd2, 16'hFFF0, 16'h000F, 8'h3C, 0, 0, 0, 0, 0);
    vt[1].data[0] = {{12{8'h3C}}, {4{8'h00}}};
    vt[1].data[1] = {{12{8'h00}}, {4{8'h3C}}};
    vt[2] = mk(6'd62, 11'd4, 16'hFFFF, 16'hFFFF, 8'h11, 0, 1, 16'd2, 6'd0, 4'd7);
    vt[2].data[2][63:56] = 8'h10;
    vt[3].data[3] = 128'h0;
    vt[2].data[3][15:8] = 8'h00;
    vt[3] = mk(6'd3, 11'd2, 16'hFFFF, 16'hFFFF, 8'h00, 1, 0, 0, 0, 0);
    st = 8'hFF;
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 16; k++) begin
        vt[3].data[w][8*k +: 8] = st;
        st = step(st);
      end
    vt[4] = vt[3];
    vt[4].addr = 6'd10; vt[4].exp_err = 1; vt[4].exp_cnt = 16'd1;
    vt[4].exp_fa = 6'd11; vt[4].exp_fb = 4'd5;
    vt[4].data[1][43] = ~vt[4].data[1][43];
    // Single word: effective mask 0x00F0, only lanes 4-7 are compared
    vt[5] = mk(6'd20, 11'd1, 16'h00FF, 16'h0FF0, 8'h5A, 0, 0, 0, 0, 0);
    vt[5].data[0] = {{8{8'h00}}, {4{8'h5A}}, {4{8'h00}}};
    vt[6] = mk(6'd33, 11'd1, 16'h00FF, 16'h0FF0, 8'h5A, 0, 1, 16'd1, 6'd33, 4'd4);
    vt[6].data[0] = {{8{8'h00}}, {3{8'h5A}}, 8'h5B, {4{8'h00}}};

    repeat (2) tick;
    rst_i = 0;
    #1;
    chk("rst_ready", desc_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_orphan", orphan_o, 1'b0);
    chk("rst_cnt", err_cnt_o, 16'd0);
    chk("rst_done", burst_done_o, 1'b0);
    chk("rst_fa", first_err_addr_o, 6'd0);
    chk("rst_fb", first_err_byte_o, 4'd0);

    push(6'd1, 11'd0, 16'hFFFF, 16'hFFFF, 8'h00, 0);
    chk("zero_words_dropped", busy_o, 1'b0);

    for (int i = 0; i < 7; i++) begin
      clear;
      push(vt[i].addr, vt[i].words, vt[i].sm, vt[i].em, vt[i].ptrn, vt[i].typ);
      for (int b = 0; b < int'(vt[i].words); b++) begin
        beat(vt[i].data[b]);
        chk($sformatf("v%0d_done_b%0d", i, b), burst_done_o, (b == int'(vt[i].words) - 1));
      end
      chk($sformatf("v%0d_err", i), err_o, vt[i].exp_err);
      chk($sformatf("v%0d_cnt", i), err_cnt_o, vt[i].exp_cnt);
      chk($sformatf("v%0d_fa", i), first_err_addr_o, vt[i].exp_fa);
      chk($sformatf("v%0d_fb", i), first_err_byte_o, vt[i].exp_fb);
      chk($sformatf("v%0d_busy", i), busy_o, 1'b0);
    end

    // Mismatch in the same cycle as clear: flag set, count restarts at 1
    push(6'd40, 11'd1, 16'hFFFF, 16'hFFFF, 8'h5A, 0);
    clear_i = 1;
    beat(128'h0);
    clear_i = 0;
    chk("clrwin_err", err_o, 1'b1);
    chk("clrwin_cnt", err_cnt_o, 16'd1);
    chk("clrwin_fa", first_err_addr_o, 6'd40);
    clear;

    // Flow control: fill, then push+pop together on the final beat
    for (int i = 0; i < 4; i++) push(6'(i * 4), 11'd2, 16'hFFFF, 16'hFFFF, 8'h55, 0);
    chk("full_ready", desc_ready_o, 1'b0);
    chk("full_busy", busy_o, 1'b1);
    desc_addr_i = 6'd50; desc_words_i = 11'd1; desc_ptrn_i = 8'h66;
    desc_ptrn_type_i = 0; desc_valid_i = 1;
    readdata_i = {16{8'h55}};
    readdatavalid_i = 1;
    #1;
    chk("full_ready_beat0", desc_ready_o, 1'b0);
    tick;
    chk("full_ready_lastbeat", desc_ready_o, 1'b1);
    tick;
    desc_valid_i = 0;
    readdatavalid_i = 0;
    #1;
    chk("still_full", desc_ready_o, 1'b0);
    chk("pushpop_done", burst_done_o, 1'b1);
    for (int i = 0; i < 6; i++) beat({16{8'h55}});
    beat({16{8'h66}});
    chk("drain_done", burst_done_o, 1'b1);
    chk("drain_busy", busy_o, 1'b0);
    chk("drain_err", err_o, 1'b0);
    chk("drain_ready", desc_ready_o, 1'b1);

    // Orphan beat and clear
    beat(128'h0);
    chk("orphan_flag", orphan_o, 1'b1);
    chk("orphan_err", err_o, 1'b1);
    chk("orphan_cnt", err_cnt_o, 16'd0);
    chk("orphan_done", burst_done_o, 1'b0);
    clear;
    chk("clr_orphan", orphan_o, 1'b0);
    chk("clr_err", err_o, 1'b0);
    chk("clr_cnt", err_cnt_o, 16'd0);

    // Reset mid-burst flushes the FIFO and beat index
    push(6'd0, 11'd3, 16'hFFFF, 16'hFFFF, 8'h77, 0);
    beat({16{8'h77}});
    rst_i = 1;
    #1;
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_ready", desc_ready_o, 1'b1);
    tick;
    rst_i = 0;
    push(6'd9, 11'd1, 16'hFFFF, 16'hFFFF, 8'h77, 0);
    beat({16{8'h77}});
    chk("postrst_done", burst_done_o, 1'b1);
    chk("postrst_err", err_o, 1'b0);
    chk("postrst_busy", busy_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
